// File: rtl/armleocpu_plic_pkg.sv
// Shared definitions for the PLIC per-context target: claim FSM encoding and ID constants.
package armleocpu_plic_pkg;

    localparam int PLIC_DEFAULT_SOURCES = 15;
    localparam int PLIC_DEFAULT_CLOG2   = 4;
    localparam int PLIC_ID_W            = PLIC_DEFAULT_CLOG2 + 1;
    localparam int PLIC_ID_NONE         = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP   = 2'd1,
        ST_SETTLE = 2'd2
    } plic_state_t;

endpackage

// File: rtl/armleocpu_plic_id_decoder.sv
// Source ID to one-hot source mask; ID 0 and IDs above the source count decode to an empty mask.
module armleocpu_plic_id_decoder
    import armleocpu_plic_pkg::*;
#(
    parameter int SOURCE_COUNT = PLIC_DEFAULT_SOURCES,
    parameter int ID_W         = PLIC_ID_W
) (
    input  logic [ID_W-1:0]         id_i,
    output logic [SOURCE_COUNT-1:0] onehot_o,
    output logic                    in_range_o
);

    always_comb begin
        in_range_o = (id_i != ID_W'(PLIC_ID_NONE)) && (id_i <= ID_W'(SOURCE_COUNT));
        onehot_o   = '0;
        // Bit k-1 stands for source k.
        for (int k = 0; k < SOURCE_COUNT; k++) begin
            onehot_o[k] = (id_i == ID_W'(k + 1));
        end
    end

endmodule

// File: rtl/armleocpu_plic_target.sv
// Per-hart PLIC claim/complete endpoint: threshold compare drives eip, claims clear gateway pending,
// completes release in-service sources. Claim response held until claim_rready; completes always accepted.
module armleocpu_plic_target
    import armleocpu_plic_pkg::*;
#(
    parameter int INTERRUPT_SOURCE_COUNT       = PLIC_DEFAULT_SOURCES,
    parameter int INTERRUPT_SOURCE_COUNT_CLOG2 = PLIC_DEFAULT_CLOG2,
    parameter int PRIORITY_WIDTH               = 32,
    localparam int ID_W                        = INTERRUPT_SOURCE_COUNT_CLOG2 + 1,
    localparam int N                           = INTERRUPT_SOURCE_COUNT
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ID_W-1:0]           max_id_in,
    input  logic [PRIORITY_WIDTH-1:0] max_priority_in,

    input  logic                      threshold_write,
    input  logic [PRIORITY_WIDTH-1:0] threshold_wdata,
    output logic [PRIORITY_WIDTH-1:0] threshold,

    output logic                      eip,

    input  logic                      claim_valid,
    output logic                      claim_ready,
    output logic                      claim_rvalid,
    input  logic                      claim_rready,
    output logic [ID_W-1:0]           claim_id,

    input  logic                      complete_valid,
    input  logic [ID_W-1:0]           complete_id,
    output logic                      complete_ignored,

    output logic [N-1:0]              pending_clear,
    output logic [N-1:0]              complete_pulse,
    output logic [N-1:0]              in_service
);

    plic_state_t               state_q, state_d;
    logic [PRIORITY_WIDTH-1:0] threshold_q;
    logic                      eip_q;
    logic                      claim_rvalid_q;
    logic [ID_W-1:0]           claim_id_q;
    logic [N-1:0]              pending_clear_q;
    logic [N-1:0]              complete_pulse_q;
    logic                      complete_ignored_q;
    logic [N-1:0]              in_service_q, in_service_d;

    logic [N-1:0] claim_onehot, complete_onehot;
    logic         claim_in_range, complete_in_range;
    logic         claim_accept, complete_hit;
    logic [N-1:0] claim_mask, complete_mask;

    armleocpu_plic_id_decoder #(
        .SOURCE_COUNT (N),
        .ID_W         (ID_W)
    ) u_claim_dec (
        .id_i       (max_id_in),
        .onehot_o   (claim_onehot),
        .in_range_o (claim_in_range)
    );

    armleocpu_plic_id_decoder #(
        .SOURCE_COUNT (N),
        .ID_W         (ID_W)
    ) u_complete_dec (
        .id_i       (complete_id),
        .onehot_o   (complete_onehot),
        .in_range_o (complete_in_range)
    );

    always_comb begin
        claim_accept  = claim_valid && (state_q == ST_IDLE);
        claim_mask    = claim_accept ? claim_onehot : '0;
        complete_hit  = complete_valid && complete_in_range && |(complete_onehot & in_service_q);
        complete_mask = complete_hit ? complete_onehot : '0;
        // A claim landing on the bit being completed keeps it in service.
        in_service_d  = (in_service_q & ~complete_mask) | claim_mask;

        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (claim_valid)  state_d = ST_RESP;
            ST_RESP:   if (claim_rready) state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            threshold_q        <= '0;
            eip_q              <= 1'b0;
            claim_rvalid_q     <= 1'b0;
            claim_id_q         <= '0;
            pending_clear_q    <= '0;
            complete_pulse_q   <= '0;
            complete_ignored_q <= 1'b0;
            in_service_q       <= '0;
        end else begin
            state_q      <= state_d;
            in_service_q <= in_service_d;
            if (threshold_write) begin
                threshold_q <= threshold_wdata;
            end
            // Gated outside IDLE so the hart never sees a stale winner while a claim settles.
            eip_q <= (state_q == ST_IDLE) && claim_in_range && (max_priority_in > threshold_q);
            claim_rvalid_q <= (state_d == ST_RESP);
            if (claim_accept) begin
                claim_id_q <= claim_in_range ? max_id_in : ID_W'(PLIC_ID_NONE);
            end
            pending_clear_q    <= claim_mask;
            complete_pulse_q   <= complete_mask;
            complete_ignored_q <= complete_valid && !complete_hit;
        end
    end

    assign threshold        = threshold_q;
    assign eip              = eip_q;
    assign claim_ready      = (state_q == ST_IDLE);
    assign claim_rvalid     = claim_rvalid_q;
    assign claim_id         = claim_id_q;
    assign pending_clear    = pending_clear_q;
    assign complete_pulse   = complete_pulse_q;
    assign complete_ignored = complete_ignored_q;
    assign in_service       = in_service_q;

endmodule

// File: doc/armleocpu_plic_target.md
Name: armleocpu_plic_target

Overview:
- Per-context (per-hart) claim/complete endpoint of the PLIC.
- Consumes the winning ID/priority at the tail of the priority-matrix cell chain and compares it against the context threshold to drive the hart's external-interrupt line.
- Serves claim reads by returning the winning ID, pulsing a pending-clear to that source's gateway and marking it in-service.
- Serves complete writes by releasing the in-service source back to its gateway.

Parameters:
- INTERRUPT_SOURCE_COUNT, 15, number of sources; IDs run 1..N and ID 0 means "none".
- INTERRUPT_SOURCE_COUNT_CLOG2, 4, ID field width minus one (ID bus is CLOG2+1 bits).
- PRIORITY_WIDTH, 32, priority and threshold width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- max_id_in  in  CLOG2+1  winning ID from the last matrix cell (0 = none).
- max_priority_in  in  PRIORITY_WIDTH  winning priority from the last matrix cell.
- threshold_write  in  1  write strobe for the threshold.
- threshold_wdata  in  PRIORITY_WIDTH  new threshold value.
- threshold  out  PRIORITY_WIDTH  current threshold.
- eip  out  1  external interrupt pending to hart (registered).
- claim_valid  in  1  claim request.
- claim_ready  out  1  claim request accepted.
- claim_rvalid  out  1  claim response valid.
- claim_rready  in  1  response consumed.
- claim_id  out  CLOG2+1  claimed ID (0 if none).
- complete_valid  in  1  complete write (always accepted).
- complete_id  in  CLOG2+1  ID being completed.
- complete_ignored  out  1  pulse: complete was not applied.
- pending_clear  out  N  one-hot pulse to gateways, bit k-1 = source k.
- complete_pulse  out  N  one-hot pulse to gateways on valid completion.
- in_service  out  N  claimed-but-not-completed mask.

Behaviour:
- Reset values: threshold=0, eip=0, claim_rvalid=0, claim_id=0, pending_clear=0, complete_pulse=0, complete_ignored=0, in_service=0, state=IDLE. Reset asserted mid-transaction aborts it: no pulse is emitted and any in-flight response is dropped.
- Threshold: on threshold_write, threshold <= threshold_wdata next cycle. The write affects eip from the following cycle.
- eip is registered: eip <= (state==IDLE) && (max_id_in!=0) && (max_priority_in > threshold). The comparison is strict and unsigned. Equal to threshold gives no interrupt.
- FSM IDLE:
  - claim_ready=1.
  - On claim_valid, capture claim_id <= max_id_in. Capture ignores the threshold.
  - If captured ID != 0: pending_clear[id-1] pulses for exactly 1 cycle and in_service[id-1] is set.
  - Go to RESP.
- FSM RESP:
  - claim_rvalid=1, claim_ready=0. claim_id is held stable.
  - On claim_rready, go to SETTLE.
- FSM SETTLE:
  - One cycle with claim_ready=0 and eip forced 0, so that gateway and matrix updates propagate.
  - Then go to IDLE.
- Claim latency: claim_rvalid rises the cycle after acceptance. Minimum back-to-back claim spacing is 3 cycles.
- Complete:
  - Accepted every cycle in any state.
  - If 1 <= complete_id <= N and in_service[id-1]: complete_pulse[id-1] fires for 1 cycle the next cycle and the bit is cleared.
  - Otherwise (ID 0, ID > N, not in service): complete_ignored fires for 1 cycle the next cycle.
- Simultaneous claim capture and complete in the same cycle: in_service_next = (in_service & ~complete_mask) | claim_mask. The claim set wins for the same bit.
- max_id_in > N is treated as 0 (no clear, claim_id=0).

Decomposition:
- Shared package armleocpu_plic_pkg holds:
  - FSM state encoding (IDLE/RESP/SETTLE).
  - ID width constant.
  - ID-0 "none" constant.
- One natural sub-module, armleocpu_plic_id_decoder: ID to N-bit one-hot with in-range flag. It is instantiated twice, once for claim and once for complete.

Test Plan:
1. Reset mid-RESP: rst=1 for 1 cycle -> all outputs 0, state IDLE, in_service=0.
2. max_id_in=3, max_priority_in=5, threshold=4 -> eip=1 after 1 cycle. Write threshold=5 -> eip=0 after 2 cycles.
3. Claim with max_id_in=3, claim_rready held 0 for 4 cycles -> claim_rvalid=1 with claim_id=3 stable throughout. pending_clear=0b100 for exactly 1 cycle, in_service[2]=1. After rready: 1 SETTLE cycle, then claim_ready=1.
4. Claim with max_id_in=0 -> claim_id=0, pending_clear=0, in_service unchanged.
5. Complete id 3 after claim -> complete_pulse=0b100 for 1 cycle, in_service[2]=0. Complete id 3 again, or id 0, or id 16 -> complete_ignored pulse, no complete_pulse.
6. Claim of id 2 and complete of id 2 (already in service) in the same cycle -> complete_pulse[1] fires and in_service[1] remains 1.
